// File: rtl/c1571_sd_responder.sv
// c1571_sd_responder: serves the drive's SD block requests from a byte-wide disk-image memory,
// moving one 512-byte block per accepted request between the image and the drive buffer.
module c1571_sd_responder #(
    parameter int IMG_BLOCKS = 683,
    parameter int MEM_AW     = 24
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic [31:0]       sd_lba_i,
    input  logic              sd_rd_i,
    input  logic              sd_wr_i,
    output logic              sd_ack_o,
    output logic [8:0]        sd_buff_addr_o,
    output logic [7:0]        sd_buff_dout_o,
    input  logic [7:0]        sd_buff_din_i,
    output logic              sd_buff_wr_o,
    input  logic              img_readonly_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o
);
    typedef enum logic [2:0] {IDLE, RD_FETCH, RD_WAIT, RD_PUT, WR_ADDR, WR_SAMPLE, WR_STORE, DONE} state_t;
    state_t             state_q, state_d;
    logic [MEM_AW-10:0] lba_q, lba_d;
    logic [8:0]         index_q, index_d;
    logic [7:0]         dout_q, dout_d, wdata_q, wdata_d;
    logic               ack_q, ack_d, oor_q, oor_d, wprot_q, wprot_d, err_q, err_d;
    logic               oor_in, last, skip_wr;

    assign oor_in  = sd_lba_i >= 32'(IMG_BLOCKS);
    assign last    = index_q == 9'd511;
    assign skip_wr = oor_q || wprot_q;

    assign sd_ack_o       = ack_q;
    assign sd_buff_addr_o = index_q;
    assign sd_buff_dout_o = dout_q;
    assign sd_buff_wr_o   = state_q == RD_PUT;
    assign mem_addr_o     = {lba_q, index_q};
    assign mem_rd_o       = (state_q == RD_FETCH || state_q == RD_WAIT) && !oor_q;
    assign mem_wr_o       = state_q == WR_STORE && !skip_wr;
    assign mem_wdata_o    = wdata_q;
    assign err_o          = err_q;

    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        index_d = index_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        oor_d   = oor_q;
        wprot_d = wprot_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (sd_rd_i || sd_wr_i) begin
                state_d = sd_rd_i ? RD_FETCH : WR_ADDR;
                lba_d   = sd_lba_i[MEM_AW-10:0];
                oor_d   = oor_in;
                wprot_d = !sd_rd_i && img_readonly_i;
                err_d   = err_q || oor_in || (!sd_rd_i && img_readonly_i);
                ack_d   = 1'b1;
            end
            // a zero-latency mem_ready in the fetch cycle is taken as well
            RD_FETCH, RD_WAIT: if (oor_q || mem_ready_i) begin
                dout_d  = oor_q ? 8'h00 : mem_rdata_i;
                state_d = RD_PUT;
            end else begin
                state_d = RD_WAIT;
            end
            // index wraps to 0 after byte 511, which leaves it cleared for DONE
            RD_PUT: begin
                index_d = index_q + 9'd1;
                state_d = last ? DONE : RD_FETCH;
                ack_d   = !last;
            end
            WR_ADDR: state_d = WR_SAMPLE;
            WR_SAMPLE: begin
                wdata_d = sd_buff_din_i;
                state_d = WR_STORE;
            end
            WR_STORE: if (skip_wr || mem_ready_i) begin
                index_d = index_q + 9'd1;
                state_d = last ? DONE : WR_ADDR;
                ack_d   = !last;
            end
            DONE: if (!sd_rd_i && !sd_wr_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            lba_q   <= '0;
            index_q <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            oor_q   <= 1'b0;
            wprot_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            index_q <= index_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            oor_q   <= oor_d;
            wprot_q <= wprot_d;
            err_q   <= err_d;
        end
    end
endmodule
